// File: rtl/br_resolve_update_pkg.sv
// Shared branch-predictor types: opcodes, resolve FSM states and the predictor update payload.
package branch_predictor;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned CNT_W = 3;

    localparam logic [OP_W-1:0] OP_BR   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR = 7'b1100111;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } br_res_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            br_en;
        logic [OP_W-1:0] opcode;
    } br_update_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/br_resolve_update_squash_fsm.sv
// Wrong-path shadow tracker: after a mispredict, marks the next SHADOW_CYCLES
// unstalled EX cycles as squashed.
module br_squash_fsm
    import branch_predictor::*;
#(
    parameter int unsigned SHADOW_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic mis,
    output logic squash_active
);

    br_res_state_t    state;
    logic [CNT_W-1:0] cnt;

    // State, shadow counter and registered squash flag; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            cnt           <= '0;
            squash_active <= 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (mis) begin
                        state         <= SQUASH;
                        cnt           <= CNT_W'(SHADOW_CYCLES);
                        squash_active <= 1'b1;
                    end
                end
                SQUASH: begin
                    if (cnt <= CNT_W'(1)) begin
                        state         <= RUN;
                        cnt           <= '0;
                        squash_active <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state         <= RUN;
                    cnt           <= '0;
                    squash_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/br_resolve_update.sv
// Branch resolve at end of EX: issues predictor updates, mispredict flush and
// redirect, and suppresses wrong-path instructions during the squash shadow.
// Optional performance counters are enabled with `define BR_PERF_CNT_EN.
module br_resolve_update
    import branch_predictor::*;
#(
    parameter int unsigned SHADOW_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [6:0]  ex_opcode,
    input  logic        ex_br_en,
    input  logic [31:0] ex_target,
    input  logic        ex_predict_dir,
    output logic [31:0] ex_mem_pc,
    output logic        ex_mem_br_en,
    output logic [6:0]  ex_mem_opcode,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        squash_active
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
`endif
);

    logic       is_br;
    logic       mis;
    br_update_t upd;

    // Only conditional branches outside the shadow qualify; JAL/JALR never do.
    assign is_br = ex_valid && (ex_opcode == OP_BR) && !squash_active;
    assign mis   = is_br && (ex_predict_dir != ex_br_en);

    br_squash_fsm #(
        .SHADOW_CYCLES(SHADOW_CYCLES)
    ) u_squash_fsm (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .mis          (mis),
        .squash_active(squash_active)
    );

    // Predictor update, flush pulse and redirect target at the EX/MEM boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd         <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else if (!stall) begin
            if (is_br) begin
                upd.pc     <= ex_pc;
                upd.br_en  <= ex_br_en;
                upd.opcode <= OP_BR;
            end else begin
                upd.br_en  <= 1'b0;
                upd.opcode <= '0;
            end
            mispredict <= mis;
            if (mis) begin
                redirect_pc <= ex_br_en ? ex_target : ex_pc + 32'd4;
            end
        end
    end

    assign ex_mem_pc     = upd.pc;
    assign ex_mem_br_en  = upd.br_en;
    assign ex_mem_opcode = upd.opcode;

`ifdef BR_PERF_CNT_EN
    // Saturating counts of resolved branches and of mispredictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (!stall) begin
            if (is_br) begin
                br_count <= sat_inc(br_count);
            end
            if (mis) begin
                mispred_count <= sat_inc(mispred_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_resolve_update.sv
// Self-checking bench for br_resolve_update (SHADOW_CYCLES = 2): a vector table
// plus a hand-built run of 10 branches with 3 mispredicts, both checked through
// an expected-result queue.
module tb_br_resolve_update;

    localparam int unsigned SC = 2;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JAL  = 7'h6f;
    localparam logic [6:0] JALR = 7'h67;

    typedef struct {
        logic [31:0] mpc;
        logic        mbr;
        logic [6:0]  mop;
        logic        mis;
        logic [31:0] rpc;
        logic        sq;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic        br_en;
        logic [31:0] tgt;
        logic        pred;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [6:0]  ex_opcode = '0;
    logic        ex_br_en = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_predict_dir = 1'b0;
    logic [31:0] ex_mem_pc;
    logic        ex_mem_br_en;
    logic [6:0]  ex_mem_opcode;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        squash_active;
`ifdef BR_PERF_CNT_EN
    logic [31:0] br_count;
    logic [31:0] mispred_count;
`endif

    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    br_resolve_update #(.SHADOW_CYCLES(SC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_opcode     (ex_opcode),
        .ex_br_en      (ex_br_en),
        .ex_target     (ex_target),
        .ex_predict_dir(ex_predict_dir),
        .ex_mem_pc     (ex_mem_pc),
        .ex_mem_br_en  (ex_mem_br_en),
        .ex_mem_opcode (ex_mem_opcode),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .squash_active (squash_active)
`ifdef BR_PERF_CNT_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    function automatic vec_t mk(
        input logic r, input logic s, input logic v, input logic [31:0] pc,
        input logic [6:0] op, input logic br, input logic [31:0] tgt, input logic pr,
        input logic [31:0] mpc, input logic mbr, input logic [6:0] mop, input logic mis,
        input logic [31:0] rpc, input logic sq, input logic [31:0] bc, input logic [31:0] mc);
        vec_t t;
        t.rst = r; t.stall = s; t.valid = v; t.pc = pc; t.op = op;
        t.br_en = br; t.tgt = tgt; t.pred = pr;
        t.e.mpc = mpc; t.e.mbr = mbr; t.e.mop = mop; t.e.mis = mis;
        t.e.rpc = rpc; t.e.sq = sq; t.e.bc = bc; t.e.mc = mc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; ex_valid = v.valid; ex_pc = v.pc;
        ex_opcode = v.op; ex_br_en = v.br_en; ex_target = v.tgt; ex_predict_dir = v.pred;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ex_mem_pc", ex_mem_pc, e.mpc);
        chk("ex_mem_br_en", 32'(ex_mem_br_en), 32'(e.mbr));
        chk("ex_mem_opcode", 32'(ex_mem_opcode), 32'(e.mop));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("squash_active", 32'(squash_active), 32'(e.sq));
`ifdef BR_PERF_CNT_EN
        chk("br_count", br_count, e.bc);
        chk("mispred_count", mispred_count, e.mc);
`endif
        step++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for 5 cycles, then idle.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // Correct taken branch; then BR opcode without ex_valid.
        tbl.push_back(mk(0,0,1,32'h100,BR,1,32'h180,1, 32'h100,1,BR,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,32'h104,BR,1,0,1,       32'h100,0,0,0,0,0,1,0));
        // Mispredict not-taken, two squashed shadow branches, then normal again.
        tbl.push_back(mk(0,0,1,32'h200,BR,0,32'h300,1, 32'h200,0,BR,1,32'h204,1,2,1));
        tbl.push_back(mk(0,0,1,32'h208,BR,1,32'h280,0, 32'h200,0,0,0,32'h204,1,2,1));
        tbl.push_back(mk(0,0,1,32'h20c,BR,1,32'h2c0,1, 32'h200,0,0,0,32'h204,0,2,1));
        tbl.push_back(mk(0,0,1,32'h300,BR,0,32'h380,0, 32'h300,0,BR,0,32'h204,0,3,1));
        tbl.push_back(mk(0,0,1,32'h304,JAL,1,32'h500,0, 32'h300,0,0,0,32'h204,0,3,1));
        // Mispredict taken, then 3 stalled cycles hold everything.
        tbl.push_back(mk(0,0,1,32'h400,BR,1,32'h4000,0, 32'h400,1,BR,1,32'h4000,1,4,2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,32'h500,BR,0,32'h600,1, 32'h400,1,BR,1,32'h4000,1,4,2));
        tbl.push_back(mk(0,0,1,32'h504,BR,1,32'h700,0, 32'h400,0,0,0,32'h4000,1,4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,               32'h400,0,0,0,32'h4000,0,4,2));
        tbl.push_back(mk(0,0,1,32'h600,BR,1,32'h640,1, 32'h600,1,BR,0,32'h4000,0,5,2));
        // Mispredict, then reset (with stall) mid-SQUASH.
        tbl.push_back(mk(0,0,1,32'h700,BR,0,32'h740,1, 32'h700,0,BR,1,32'h704,1,6,3));
        tbl.push_back(mk(1,1,1,32'h800,BR,1,32'h900,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,32'h800,BR,1,32'h900,0, 32'h800,1,BR,1,32'h900,1,1,1));
        tbl.push_back(mk(0,0,1,32'h804,BR,0,0,1,       32'h800,0,0,0,32'h900,1,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,               32'h800,0,0,0,32'h900,0,1,1));
        // PC+4 wrap on a not-taken mispredict at the top of the address space.
        tbl.push_back(mk(0,0,1,32'hFFFFFFFC,BR,0,32'h10,1, 32'hFFFFFFFC,0,BR,1,0,1,2,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,               32'hFFFFFFFC,0,0,0,0,1,2,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,               32'hFFFFFFFC,0,0,0,0,0,2,2));
        tbl.push_back(mk(0,0,1,32'h900,JALR,1,32'hA00,0, 32'hFFFFFFFC,0,0,0,0,0,2,2));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Fresh reset, then 10 real branches with mispredicts at 2, 5, 8; each
        // mispredict is followed by SC squashed branches that must not count.
        begin
            logic [31:0] rpc_e;
            logic [31:0] last_pc;
            int          mcnt;
            run_vec(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
            rpc_e = 0;
            mcnt  = 0;
            for (int i = 0; i < 10; i++) begin
                logic        m;
                logic        be;
                logic [31:0] pc;
                logic [31:0] tg;
                m  = (i == 2) || (i == 5) || (i == 8);
                be = 1'(i % 2);
                pc = 32'h1000 + 32'(i * 16);
                tg = 32'h8000 + 32'(i * 256);
                if (m) begin
                    mcnt++;
                    rpc_e = be ? tg : pc + 32'd4;
                end
                run_vec(mk(0,0,1,pc,BR,be,tg,m ? ~be : be,
                           pc,be,BR,m,rpc_e,m,32'(i + 1),32'(mcnt)));
                last_pc = pc;
                if (m) begin
                    for (int k = 0; k < int'(SC); k++)
                        run_vec(mk(0,0,1,32'h9000 + 32'(k * 4),BR,1,32'hF000,0,
                                   last_pc,0,0,0,rpc_e,(k < int'(SC) - 1),32'(i + 1),32'(mcnt)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
